// File: rtl/param_report_tx.sv
// Streams elaboration-time parameter name/value pairs as ASCII lines "NAME=0xHHHH\n"
// over a byte-wide valid/ready interface; inputs are captured when a report starts.
module param_report_tx #(
  parameter int unsigned NUM_PARAMS = 4,
  parameter int unsigned NAME_LEN   = 8,
  parameter int unsigned VALUE_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_PARAMS*NAME_LEN*8-1:0] names,
  input  logic [NUM_PARAMS*VALUE_W-1:0]    values,
  output logic                             busy,
  output logic                             done,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready
);

  localparam int unsigned NB   = NAME_LEN * 8;
  localparam int unsigned NIBS = VALUE_W / 4;
  localparam int unsigned CW   = (NAME_LEN > 1)   ? $clog2(NAME_LEN)   : 1;
  localparam int unsigned NW   = (NIBS > 1)       ? $clog2(NIBS)       : 1;
  localparam int unsigned EW   = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NAME,
    S_EQ,
    S_PFX0,
    S_PFX1,
    S_HEX,
    S_NL,
    S_FIN
  } state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  char_q, char_d;
  logic [NW-1:0]                  nib_q, nib_d;
  logic [EW-1:0]                  entry_q, entry_d;
  logic [NUM_PARAMS*NB-1:0]       names_q;
  logic [NUM_PARAMS*VALUE_W-1:0]  values_q;

  logic [EW-1:0]      nxt_entry;
  logic               last_entry;
  logic [NB-1:0]      cur_name;
  logic [NB-1:0]      next_name;
  logic [VALUE_W-1:0] cur_val;
  logic [3:0]         nibble;
  logic [7:0]         cur_char;
  logic [7:0]         hex_char;
  logic [CW:0]        hit;

  // Returns {found, index} of the first non-NUL character at or after 'from'.
  // The char index therefore always points at a byte worth sending, so NULs cost no cycle.
  function automatic logic [CW:0] seek(input logic [NB-1:0] name, input int unsigned from);
    logic [CW:0] r;
    r = '0;
    for (int unsigned k = NAME_LEN; k > 0; k--) begin
      if ((k - 1) >= from && name[(NAME_LEN - k)*8 +: 8] != 8'h00) begin
        r = {1'b1, CW'(k - 1)};
      end
    end
    return r;
  endfunction

  assign last_entry = (entry_q == EW'(NUM_PARAMS - 1));
  assign nxt_entry  = last_entry ? '0 : entry_q + 1'b1;
  assign cur_name   = names_q[entry_q*NB +: NB];
  assign next_name  = names_q[nxt_entry*NB +: NB];
  assign cur_val    = values_q[entry_q*VALUE_W +: VALUE_W];
  assign nibble     = cur_val[nib_q*4 +: 4];
  assign cur_char   = cur_name[(NAME_LEN - 1 - char_q)*8 +: 8];
  assign hex_char   = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      char_q   <= '0;
      nib_q    <= '0;
      entry_q  <= '0;
      names_q  <= '0;
      values_q <= '0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      nib_q   <= nib_d;
      entry_q <= entry_d;
      if (state_q == S_IDLE && start) begin
        names_q  <= names;
        values_q <= values;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    char_d   = char_q;
    nib_d    = nib_q;
    entry_d  = entry_q;
    busy     = 1'b0;
    done     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    hit      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Captured names are not registered yet, so search the live input for entry 0.
          entry_d = '0;
          hit     = seek(names[NB-1:0], 0);
          char_d  = hit[CW-1:0];
          state_d = hit[CW] ? S_NAME : S_EQ;
        end
      end
      S_NAME: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = cur_char;
        if (tx_ready) begin
          hit     = seek(cur_name, 32'(char_q) + 1);
          char_d  = hit[CW-1:0];
          state_d = hit[CW] ? S_NAME : S_EQ;
        end
      end
      S_EQ: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h3D;
        if (tx_ready) state_d = S_PFX0;
      end
      S_PFX0: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h30;
        if (tx_ready) state_d = S_PFX1;
      end
      S_PFX1: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h78;
        if (tx_ready) begin
          nib_d   = NW'(NIBS - 1);
          state_d = S_HEX;
        end
      end
      S_HEX: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = hex_char;
        if (tx_ready) begin
          if (nib_q == '0) state_d = S_NL;
          else             nib_d   = nib_q - 1'b1;
        end
      end
      S_NL: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) begin
          if (last_entry) begin
            state_d = S_FIN;
          end else begin
            entry_d = nxt_entry;
            hit     = seek(next_name, 0);
            char_d  = hit[CW-1:0];
            state_d = hit[CW] ? S_NAME : S_EQ;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_param_report_tx.sv
// Directed bench for param_report_tx: two instances (2x5-char/16-bit and 1x1-char/4-bit)
// checked against hand-written expected ASCII reports.
module tb_param_report_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start, a_busy, a_done, a_valid, a_ready;
  logic [7:0]  a_data;
  logic [79:0] a_names;
  logic [31:0] a_values;

  logic        b_start, b_busy, b_done, b_valid, b_ready;
  logic [7:0]  b_data;
  logic [7:0]  b_names;
  logic [3:0]  b_values;

  localparam logic [79:0] BASIC_N = {"DEPTH", "WIDTH"};
  localparam logic [31:0] BASIC_V = {16'h0010, 16'h0008};
  localparam string       BASIC_S = "WIDTH=0x0008\nDEPTH=0x0010\n";
  localparam logic [79:0] CHG_N   = {"BBBBB", "AAAAA"};
  localparam logic [31:0] CHG_V   = {16'h1234, 16'hABCD};
  localparam string       CHG_S   = "AAAAA=0xABCD\nBBBBB=0x1234\n";
  localparam string       B_S     = "A=0xF\n";

  param_report_tx #(.NUM_PARAMS(2), .NAME_LEN(5), .VALUE_W(16)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .names(a_names), .values(a_values),
    .busy(a_busy), .done(a_done), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready)
  );

  param_report_tx #(.NUM_PARAMS(1), .NAME_LEN(1), .VALUE_W(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .names(b_names), .values(b_values),
    .busy(b_busy), .done(b_done), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rxq[$];
  int         busy_cnt  = 0;
  int         done_cnt  = 0;
  int         stall_err = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe instance A mid-cycle: collect transferred bytes, busy/done counts, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (a_valid !== 1'b1 || a_data !== held)) stall_err++;
      if (a_valid && a_ready) rxq.push_back(a_data);
      if (a_busy) busy_cnt++;
      if (a_done) done_cnt++;
      stall_prev = a_valid && !a_ready;
      held       = a_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rxq.delete();
    busy_cnt  = 0;
    done_cnt  = 0;
    stall_err = 0;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input bit rnd, input int budget);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      if (rnd) a_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    a_ready = 1'b1;
    check("done_timeout", 32'(cyc < budget), 1);
  endtask

  task automatic compare_a(input string tag, input string exp);
    check($sformatf("%s_len", tag), rxq.size(), exp.len());
    for (int i = 0; i < exp.len() && i < rxq.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), rxq[i], exp[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst      = 1'b1;
    a_start  = 1'b0;
    a_ready  = 1'b1;
    a_names  = BASIC_N;
    a_values = BASIC_V;
    b_start  = 1'b0;
    b_ready  = 1'b1;
    b_names  = "A";
    b_values = 4'hF;
    #2;
    check("rst_busy",  a_busy,  0);
    check("rst_done",  a_done,  0);
    check("rst_valid", a_valid, 0);
    check("rst_data",  a_data,  0);
    check("rst_b_valid", b_valid, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Basic report, sink always ready
    clear_mon();
    start_a();
    check("lat_valid", a_valid, 1);
    check("lat_busy",  a_busy,  1);
    check("lat_data",  a_data,  8'h57);
    wait_done_a(1'b0, 200);
    compare_a("basic", BASIC_S);
    check("basic_busy_cycles", busy_cnt, 26);
    check("basic_done_pulses", done_cnt, 1);
    check("basic_idle_valid",  a_valid, 0);

    // Leading-NUL name and all-NUL name
    a_names  = {40'h0, 16'h0000, "OFS"};
    a_values = {16'h002A, 16'hDEAD};
    clear_mon();
    start_a();
    check("nul_first", a_data, 8'h4F);
    wait_done_a(1'b0, 200);
    compare_a("nul", "OFS=0xDEAD\n=0x002A\n");
    check("nul_busy_cycles", busy_cnt, 19);
    check("nul_done_pulses", done_cnt, 1);

    // Random backpressure
    a_names  = BASIC_N;
    a_values = BASIC_V;
    clear_mon();
    start_a();
    wait_done_a(1'b1, 600);
    compare_a("bp", BASIC_S);
    check("bp_stall_hold",   stall_err, 0);
    check("bp_done_pulses",  done_cnt, 1);

    // Inputs change and start re-pulsed mid-report; start in FIN ignored
    clear_mon();
    start_a();
    repeat (5) tick();
    a_names  = CHG_N;
    a_values = CHG_V;
    a_start  = 1'b1;
    tick();
    a_start  = 1'b0;
    cyc = 0;
    while (!a_done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("fin_timeout", 32'(cyc < 200), 1);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("fin_start_busy",  a_busy,  0);
    check("fin_start_valid", a_valid, 0);
    compare_a("hold", BASIC_S);
    check("hold_done_pulses", done_cnt, 1);

    // Start in the cycle after done uses the new inputs
    clear_mon();
    start_a();
    check("restart_valid", a_valid, 1);
    wait_done_a(1'b0, 200);
    compare_a("restart", CHG_S);

    // Asynchronous reset after the 7th byte
    a_names  = BASIC_N;
    a_values = BASIC_V;
    clear_mon();
    start_a();
    cyc = 0;
    while (rxq.size() < 7 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("mid_rst_reach", rxq.size(), 7);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_busy",  a_busy,  0);
    check("mid_rst_done",  a_done,  0);
    tick();
    rst = 1'b0;
    tick();
    clear_mon();
    start_a();
    wait_done_a(1'b0, 200);
    compare_a("post_rst", BASIC_S);
    check("post_rst_done_pulses", done_cnt, 1);

    // Width corner: one 1-char name, 4-bit value
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("w_busy", b_busy, 1);
    for (int i = 0; i < B_S.len(); i++) begin
      check($sformatf("w_valid%0d", i), b_valid, 1);
      check($sformatf("w_b%0d", i), b_data, B_S[i]);
      tick();
    end
    check("w_done",       b_done,  1);
    check("w_done_valid", b_valid, 0);
    check("w_done_busy",  b_busy,  0);
    tick();
    check("w_done_single", b_done, 0);
    check("w_idle_busy",   b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_report_tx.md
Name: param_report_tx

Overview:
- Transmitter that serialises a set of named parameter values as ASCII text lines of the form `NAME=0xHHHH\n` onto a byte stream with a valid/ready handshake.
- Software and host tooling use this stream to read back the elaboration-time parameter defaults of a built design; it is the emitting end of the parameter-readback path.
- Sits between a configuration/ID register bank and a byte-wide UART or debug FIFO.

Parameters:
- NUM_PARAMS, 4, number of name/value pairs reported; must be ≥1.
- NAME_LEN, 8, characters per name field; must be ≥1.
- VALUE_W, 32, bits per value; must be a multiple of 4 and ≥4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a report.
- names  in  NUM_PARAMS*NAME_LEN*8  packed ASCII names. Entry i occupies bits [(i+1)*NAME_LEN*8-1 : i*NAME_LEN*8]; the first character is the most significant byte of the entry.
- values  in  NUM_PARAMS*VALUE_W  packed values. Entry i occupies bits [(i+1)*VALUE_W-1 : i*VALUE_W].
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte of the report is accepted.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte; a transfer occurs when tx_valid && tx_ready.

Behaviour:
- Reset values: busy=0, done=0, tx_valid=0, tx_data=8'h00; FSM in IDLE. Reset is asynchronous, so an active reset mid-report drops tx_valid immediately and discards the rest of the report.
- Start acceptance:
  - start is accepted only in IDLE. It is ignored while busy=1 and in the cycle done is high.
  - On acceptance, names and values are captured into internal registers; input changes after that do not affect the report in progress.
- Latency: the first byte appears with tx_valid=1 in the cycle after start is accepted; busy rises in the same cycle.
- FSM states: IDLE → NAME → EQ → PFX0 → PFX1 → HEX → NL → (NAME for the next entry, or FIN) → IDLE.
- Per-entry byte sequence, entries in order 0 to NUM_PARAMS-1:
  - NAME: name characters, first to last. Any byte equal to 8'h00 is skipped and consumes no cycle on the stream. An all-NUL name emits nothing and goes directly to EQ.
  - EQ emits '=' (8'h3D). PFX0 emits '0' (8'h30). PFX1 emits 'x' (8'h78).
  - HEX emits VALUE_W/4 digits, most significant nibble first. Digits 0–9 map to 8'h30–8'h39; 10–15 map to uppercase 'A'–'F' (8'h41–8'h46). Leading zeros are not suppressed.
  - NL emits 8'h0A.
  - Bytes per entry = (count of non-NUL name chars) + 3 + VALUE_W/4 + 1.
- Handshake rules:
  - A state or character counter advances only on a transfer.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable and tx_valid stays high.
  - tx_valid never drops between bytes of a report; back-to-back transfers occur at one byte per cycle while tx_ready=1.
- Completion:
  - FIN is entered on the transfer of the final NL. The following cycle has done=1, busy=0 and tx_valid=0; the FSM then returns to IDLE.
  - A start arriving in the FIN cycle is ignored.
- Counters: the name character index counts from 0 to NAME_LEN-1, the nibble index from VALUE_W/4-1 down to 0, and the entry index from 0 to NUM_PARAMS-1. They wrap or reset on entry to the next field; none of them may overflow.
- tx_ready held low indefinitely stalls the FSM with no timeout.

Test Plan:
- Basic report (NUM_PARAMS=2, NAME_LEN=5, VALUE_W=16; names "WIDTH","DEPTH"; values 16'h0008, 16'h0010; tx_ready=1; start pulse) → 26 consecutive bytes "WIDTH=0x0008\nDEPTH=0x0010\n"; first byte the cycle after start; done pulse one cycle after the last 8'h0A; busy high for exactly 26 cycles.
- NUL padding: name 8'h00,8'h00,"OFS" with value 16'hDEAD → "OFS=0xDEAD\n" (11 bytes, hex uppercase). An all-NUL name with value 16'h002A → "=0x002A\n".
- Backpressure: tx_ready toggles 1,0,0,1,… pseudo-randomly → byte sequence identical to the basic case; tx_data stable during every stall; no dropped or duplicated bytes.
- Input change and restart: change names/values and pulse start mid-report → the report uses the values captured at the original start; the extra start is ignored; a start the cycle after done begins a new report.
- Reset mid-report: assert rst after the 7th byte → tx_valid, busy and done are 0 immediately. After release, a start produces the full report from byte 0.
- Width corner: VALUE_W=4, NUM_PARAMS=1, name "A" with value 4'hF → "A=0xF\n" and a single done pulse.
